// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard/sequencing controller:
// controller states, register-zero constant and counter widths.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MD_BUSY  = 2'd2
    } hz_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int         WAIT_W   = 8;
    localparam int         STALL_W  = 32;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational hazard compare: load-use against the EX load destination and
// hi/lo or mul/div conflicts while the mul/div unit is still in flight.
module hazard_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       id_reads_hilo,
    input  logic       id_muldiv,
    input  logic       ex_re,
    input  logic [4:0] ex_rd,
    input  logic       md_busy,
    input  logic       muldiv_done,
    output logic       load_use,
    output logic       md_conflict
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = id_use_rs && (id_rs == ex_rd);
    assign rt_hit = id_use_rt && (id_rt == ex_rd);

    // $0 is never a real producer, so a load targeting it cannot create a hazard
    assign load_use    = ex_re && (ex_rd != REG_ZERO) && (rs_hit || rt_hit);
    assign md_conflict = md_busy && (id_reads_hilo || id_muldiv) && !muldiv_done;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard and sequencing controller: memory-wait / mul-div FSM,
// output priority mux for pipeline register controls, stall and timeout tracking.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [4:0]         id_rs,
    input  logic [4:0]         id_rt,
    input  logic               id_use_rs,
    input  logic               id_use_rt,
    input  logic               id_reads_hilo,
    input  logic               id_muldiv,
    input  logic               ex_re,
    input  logic [4:0]         ex_rd,
    input  logic               ex_muldiv_start,
    input  logic               muldiv_done,
    input  logic               branch_taken,
    input  logic               jump,
    input  logic               mem_req,
    input  logic               mem_ready,
    output logic               pc_we,
    output logic               ifid_we,
    output logic               ifid_flush,
    output logic               idex_stall,
    output logic               idex_hold,
    output logic               exmem_hold,
    output logic               memwb_bubble,
    output logic               mem_timeout,
    output logic [STALL_W-1:0] stall_cycles
);

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

    hz_state_e         state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              md_pending;
    logic              load_use, md_conflict;
    logic              mem_miss, wait_below, wait_exit, timed_out, mem_stall;

    hazard_detect u_hazard_detect (
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_use_rs     (id_use_rs),
        .id_use_rt     (id_use_rt),
        .id_reads_hilo (id_reads_hilo),
        .id_muldiv     (id_muldiv),
        .ex_re         (ex_re),
        .ex_rd         (ex_rd),
        .md_busy       (state == MD_BUSY),
        .muldiv_done   (muldiv_done),
        .load_use      (load_use),
        .md_conflict   (md_conflict)
    );

    assign mem_miss   = mem_req && !mem_ready;
    assign wait_below = wait_cnt < WAIT_LIMIT;
    assign wait_exit  = mem_ready || !wait_below;
    assign timed_out  = (state == MEM_WAIT) && !mem_ready && !wait_below;
    // Outside MEM_WAIT any unfinished access holds the pipe, including while mul/div runs
    assign mem_stall  = (state == MEM_WAIT) ? (!mem_ready && wait_below) : mem_miss;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= RUN;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (mem_miss)             state_nxt = MEM_WAIT;
                else if (ex_muldiv_start) state_nxt = MD_BUSY;
            end
            MEM_WAIT: begin
                if (wait_exit) state_nxt = (md_pending && !muldiv_done) ? MD_BUSY : RUN;
            end
            MD_BUSY: begin
                if (mem_miss)         state_nxt = MEM_WAIT;
                else if (muldiv_done) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        pc_we        = 1'b0;
        ifid_we      = 1'b0;
        ifid_flush   = 1'b0;
        idex_stall   = 1'b0;
        idex_hold    = 1'b0;
        exmem_hold   = 1'b0;
        memwb_bubble = 1'b0;
        if (reset_n) begin
            if (mem_stall) begin
                idex_hold    = 1'b1;
                exmem_hold   = 1'b1;
                memwb_bubble = 1'b1;
            end else if (load_use || md_conflict) begin
                idex_stall = 1'b1;
            end else if (branch_taken || jump) begin
                pc_we      = 1'b1;
                ifid_we    = 1'b1;
                ifid_flush = 1'b1;
                idex_stall = 1'b1;
            end else begin
                pc_we        = 1'b1;
                ifid_we      = 1'b1;
                // an abandoned access must not reach writeback
                memwb_bubble = timed_out;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                  wait_cnt <= '0;
        else if (state_nxt == MEM_WAIT) wait_cnt <= (state == MEM_WAIT) ? wait_cnt + WAIT_W'(1)
                                                                        : WAIT_W'(1);
        else                           wait_cnt <= '0;
    end

    // Remembers a mul/div launch that overlapped a memory wait
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            md_pending <= 1'b0;
        end else if (state == MEM_WAIT) begin
            if (muldiv_done || wait_exit) md_pending <= 1'b0;
        end else if (mem_miss) begin
            md_pending <= (state == RUN) ? ex_muldiv_start : !muldiv_done;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)       mem_timeout <= 1'b0;
        else if (timed_out) mem_timeout <= 1'b1;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                           stall_cycles <= '0;
        else if (!pc_we && (stall_cycles != '1)) stall_cycles <= stall_cycles + STALL_W'(1);
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and sequencing controller for the 5-stage MIPS pipeline. Each cycle it decides whether each pipeline register advances, holds, or loads a bubble. It covers load-use hazards, branch/jump squashes, a multi-cycle mul/div unit and a data-memory wait handshake, and drives the ID/EX register's `stall` input plus the PC, IF/ID, EX/MEM and MEM/WB enables. It also keeps a saturating stall-cycle counter and a sticky memory-timeout flag.

## Interface
- `MEM_TIMEOUT`, default 255: maximum wait cycles on `mem_ready` before the request is abandoned (1..255).
- `clock`  in  1  rising-edge system clock
- `reset_n`  in  1  asynchronous, active-low reset
- `id_rs`, `id_rt`  in  5 each  source register fields of the instruction in ID
- `id_use_rs`, `id_use_rt`  in  1 each  ID instruction reads `rs` / `rt`
- `id_reads_hilo`  in  1  ID instruction is mfhi/mflo
- `id_muldiv`  in  1  ID instruction is mult/div
- `ex_re`  in  1  EX instruction is a load (`re_inIDEX`)
- `ex_rd`  in  5  EX destination register
- `ex_muldiv_start`  in  1  mul/div unit accepted an operation this cycle
- `muldiv_done`  in  1  mul/div result valid (one-cycle pulse)
- `branch_taken`, `jump`  in  1 each  ID-resolved redirect
- `mem_req`  in  1  MEM stage issues a data access
- `mem_ready`  in  1  data memory completes the access
- `pc_we`  out  1  PC update enable
- `ifid_we`  out  1  IF/ID load enable
- `ifid_flush`  out  1  IF/ID loads a NOP
- `idex_stall`  out  1  ID/EX loads a bubble
- `idex_hold`  out  1  ID/EX keeps its contents
- `exmem_hold`  out  1  EX/MEM keeps its contents
- `memwb_bubble`  out  1  MEM/WB loads a bubble
- `mem_timeout`  out  1  sticky; set on timeout
- `stall_cycles`  out  32  saturating count of cycles with `pc_we`=0

## Operation
- States:
  - `RUN`: normal operation.
  - `MEM_WAIT`: MEM stage waiting on `mem_ready`.
  - `MD_BUSY`: mul/div unit in flight.
- Hazard terms:
  - Load-use: `ex_re` && `ex_rd`≠0 && ((`id_use_rs` && `id_rs`==`ex_rd`) || (`id_use_rt` && `id_rt`==`ex_rd`)).
  - Mul/div conflict: state is `MD_BUSY` && (`id_reads_hilo` || `id_muldiv`) && !`muldiv_done`.
  - Memory wait: (`mem_req` && !`mem_ready` in `RUN`) or (state `MEM_WAIT` && !`mem_ready` && count<`MEM_TIMEOUT`).
- Output priority, highest first:
  - Memory wait: `pc_we`=`ifid_we`=0, `idex_hold`=`exmem_hold`=1, `memwb_bubble`=1, `idex_stall`=0, `ifid_flush`=0.
  - Load-use or mul/div conflict: `pc_we`=`ifid_we`=0, `idex_stall`=1. Any redirect is ignored this cycle; the stalled instruction re-evaluates next cycle.
  - `branch_taken` or `jump`: `ifid_flush`=1, `idex_stall`=1, `pc_we`=1.
  - Otherwise: `pc_we`=`ifid_we`=1, all other control outputs 0.
- State transitions:
  - `RUN`→`MEM_WAIT`: `mem_req` && !`mem_ready`. Wait counter loads 1.
  - `MEM_WAIT`→`RUN`: `mem_ready`, or counter reaches `MEM_TIMEOUT`. On timeout, set `mem_timeout` and release the pipeline; the access is dropped and MEM/WB receives a bubble.
  - `RUN`→`MD_BUSY`: `ex_muldiv_start`. If a memory wait begins in the same cycle, `MEM_WAIT` takes precedence and a pending-md flag is recorded; on exit from `MEM_WAIT` the next state is `MD_BUSY` unless `muldiv_done` was seen meanwhile.
  - `MD_BUSY`→`RUN`: `muldiv_done`. A same-cycle `mem_req` && !`mem_ready` moves directly to `MEM_WAIT` instead.
- The wait counter is 8 bits, increments each `MEM_WAIT` cycle, and clears on leaving `MEM_WAIT`.
- `stall_cycles` increments every cycle with `pc_we`=0 and saturates at 0xFFFF_FFFF.

## Timing
- All outputs except `mem_timeout` and `stall_cycles` are combinational from the current state and inputs, with zero-cycle latency.
- `mem_timeout` and `stall_cycles` are registered. `mem_timeout` clears only on reset.
- Reset (`reset_n`=0, asynchronous) forces:
  - state `RUN`, counters 0, `mem_timeout`=0;
  - `pc_we`=`ifid_we`=0, all other outputs 0.
- After reset deasserts, outputs follow the `RUN` rules from the first clock edge.
- Reset asserted mid-`MEM_WAIT` or mid-`MD_BUSY` abandons the operation immediately.
- Load-use costs exactly one bubble: on the next cycle the bubble sits in EX, so the hazard term drops.
- A `mem_ready` arriving in the same cycle as `mem_req` causes no stall.

## Structure
- The shared pipeline package holds:
  - the state enum (`RUN`, `MEM_WAIT`, `MD_BUSY`);
  - the register-zero constant (5'd0);
  - the counter widths (8-bit wait, 32-bit stall).
- One sub-module, `hazard_detect`, holds the purely combinational load-use and mul/div-conflict compare.
- The FSM, counters and output priority mux live in the top module.

## Test plan
- Load to `$5` in EX (`ex_re`=1, `ex_rd`=5), ID reads `rs`=5 → one cycle with `pc_we`=0, `idex_stall`=1; following cycle all enables 1.
- `ex_rd`=0 with `ex_re`=1 and `id_rs`=0 → no stall.
- `branch_taken`=1 with no hazard → `ifid_flush`=1, `idex_stall`=1, `pc_we`=1.
- `branch_taken`=1 together with load-use → stall only, `ifid_flush`=0.
- `mem_req`=1, `mem_ready` low for 3 cycles → 3 cycles of `idex_hold`=`exmem_hold`=1 and `memwb_bubble`=1; `stall_cycles` increases by 3.
- `MEM_TIMEOUT`=4 with `mem_ready` never asserted → release after 4 wait cycles; `mem_timeout`=1 and stays 1 until `reset_n`=0.
- `ex_muldiv_start`, then mflo in ID, `muldiv_done` 6 cycles later → `idex_stall`=1 for each cycle before done; on the `muldiv_done` cycle `idex_stall`=0 and the state returns to `RUN`.
- Assert `reset_n`=0 mid-`MD_BUSY` → state `RUN` and `stall_cycles`=0 immediately, without waiting for a clock edge.
